// File: rtl/alu_pkg.sv
// Shared ALU definitions: nibble width, controller state encoding and saturation bounds.
package alu_pkg;

  localparam int unsigned NIBBLE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Returned 64 bits wide; callers keep the low w bits.
  function automatic logic [63:0] sat_pos(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_neg(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_ctrl_cla4.sv
// 4-bit carry-lookahead adder slice (purely combinational), with group G/P and signed overflow.
module nibble_serial_addsub_ctrl_cla4
  import alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  input  logic                sub,
  output logic [NIBBLE_W-1:0] sum,
  output logic                g_grp,
  output logic                p_grp,
  output logic                ovfl
);

  logic [NIBBLE_W-1:0] bx;
  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  always_comb begin
    bx   = sub ? ~b : b;
    g    = a & bx;
    p    = a ^ bx;
    c[0] = sub | cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum   = p ^ c[NIBBLE_W-1:0];
    g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    p_grp = &p;
    ovfl  = c[4] ^ c[3];
  end

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// Nibble-serial signed add/subtract controller around one 4-bit CLA slice.
// Optional saturation on signed overflow: define ADDSUB_SAT_EN.
module nibble_serial_addsub_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovfl,
  output logic             zero
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

`ifdef ADDSUB_SAT_EN
  localparam logic [63:0]      SAT_POS_W = sat_pos(WIDTH);
  localparam logic [63:0]      SAT_NEG_W = sat_neg(WIDTH);
  localparam logic [WIDTH-1:0] SAT_POS_V = SAT_POS_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SAT_NEG_V = SAT_NEG_W[WIDTH-1:0];
`endif

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovfl_q, ovfl_d;
  logic             zero_q, zero_d;

  logic [NIBBLE_W-1:0] sl_a, sl_b, sl_sum;
  logic                sl_g, sl_p, sl_ovfl;
  logic [WIDTH-1:0]    acc_merged;
  logic [WIDTH-1:0]    final_res;

  // B is already inverted for subtraction, so the slice's own subtract path stays off.
  nibble_serial_addsub_ctrl_cla4 u_cla4 (
    .a     (sl_a),
    .b     (sl_b),
    .cin   (carry_q),
    .sub   (1'b0),
    .sum   (sl_sum),
    .g_grp (sl_g),
    .p_grp (sl_p),
    .ovfl  (sl_ovfl)
  );

  always_comb begin
    sl_a       = '0;
    sl_b       = '0;
    acc_merged = acc_q;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sl_a = op_a_q[i*NIBBLE_W +: NIBBLE_W];
        sl_b = op_b_q[i*NIBBLE_W +: NIBBLE_W];
        acc_merged[i*NIBBLE_W +: NIBBLE_W] = sl_sum;
      end
    end
  end

  always_comb begin
`ifdef ADDSUB_SAT_EN
    // Overflow always flips the sign away from A, so A's MSB picks the saturation bound.
    final_res = acc_merged;
    if (sl_ovfl) final_res = op_a_q[WIDTH-1] ? SAT_NEG_V : SAT_POS_V;
`else
    final_res = acc_merged;
`endif
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    result_d = result_q;
    ovfl_d   = ovfl_q;
    zero_d   = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CALC;
          op_a_d  = a;
          op_b_d  = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
        end
      end
      ST_CALC: begin
        acc_d   = acc_merged;
        carry_d = sl_g | (sl_p & carry_q);
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d  = ST_DONE;
          result_d = final_res;
          ovfl_d   = sl_ovfl;
          zero_d   = (final_res == '0);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      ovfl_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      carry_q  <= carry_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovfl_q   <= ovfl_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = (state_q == ST_CALC);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign ovfl   = ovfl_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Self-checking bench for nibble_serial_addsub_ctrl (WIDTH=16); honours ADDSUB_SAT_EN.
module tb_nibble_serial_addsub_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n, start, sub;
  logic [W-1:0] a, b;
  logic         busy, done, ovfl, zero;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .sub    (sub),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovfl   (ovfl),
    .zero   (zero)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] r;
    logic         v;
    logic         z;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact signed integer arithmetic, then range test and truncation.
  function automatic void model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                                output logic [W-1:0] r, output logic v, output logic z);
    longint sa, sb, s;
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    s  = isub ? sa - sb : sa + sb;
    v  = (s > 32767) || (s < -32768);
    r  = s[W-1:0];
`ifdef ADDSUB_SAT_EN
    if (v) r = (s > 0) ? 16'h7FFF : 16'h8000;
`endif
    z = (r == '0);
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic isub, input logic [W-1:0] er, input logic ev, input logic ez);
    int lat;
    start = 1'b1; a = ia; b = ib; sub = isub;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'd5);
    chk({tag, " result"}, 32'(result), 32'(er));
    chk({tag, " ovfl"}, 32'(ovfl), 32'(ev));
    chk({tag, " zero"}, 32'(zero), 32'(ez));
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
    chk({tag, " held"}, 32'(result), 32'(er));
  endtask

  vec_t tbl[8];
  logic [W-1:0] hold_a[18];
  logic [W-1:0] hold_b[18];
  logic         hold_s[18];

  initial begin
    logic [W-1:0] er, ra, rb;
    logic         ev, ez, rs;

    tbl[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    tbl[1] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b0, 1'b1};
    tbl[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[3] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};
`ifdef ADDSUB_SAT_EN
    tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b0};
    tbl[5] = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b0};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b0};
    tbl[7] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h7FFF, 1'b1, 1'b0};
`else
    tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1, 1'b0};
    tbl[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[7] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b1, 1'b0};
`endif

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    #2;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset ovfl", 32'(ovfl), 32'd0);
    chk("reset zero", 32'(zero), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].r, tbl[i].v, tbl[i].z);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      if (i % 8 == 0) ra = {1'b0, {(W-1){1'b1}}};
      if (i % 8 == 1) ra = {1'b1, {(W-1){1'b0}}};
      model(ra, rb, rs, er, ev, ez);
      run_op($sformatf("rnd%0d", i), ra, rb, rs, er, ev, ez);
    end

    // start held high with new operands every cycle: acceptances land every 6 edges.
    for (int e = 0; e < 18; e++) begin
      start = 1'b1;
      hold_a[e] = W'($urandom); hold_b[e] = W'($urandom); hold_s[e] = 1'($urandom);
      a = hold_a[e]; b = hold_b[e]; sub = hold_s[e];
      @(posedge clk); #1;
      chk($sformatf("held_start done e%0d", e), 32'(done), 32'(e % 6 == 4));
      if (e % 6 == 4) begin
        model(hold_a[e-4], hold_b[e-4], hold_s[e-4], er, ev, ez);
        chk($sformatf("held_start result e%0d", e), 32'(result), 32'(er));
        chk($sformatf("held_start ovfl e%0d", e), 32'(ovfl), 32'(ev));
      end
    end
    start = 1'b0;
    @(posedge clk); #1;

    run_op("pre_reset", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    start = 1'b1; a = 16'h4321; b = 16'h1111; sub = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    chk("midreset result", 32'(result), 32'd0);
    chk("midreset ovfl", 32'(ovfl), 32'd0);
    chk("midreset zero", 32'(zero), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_reset", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
